// File: rtl/dbus_responder.sv
// Load/store responder: word RAM, memory-mapped output FIFO, free-running timer with compare IRQ.
// Loads are combinational and stores land on the next edge; pushes to a full FIFO without a same-cycle pop are dropped and set ovf.
module dbus_responder #(
  parameter int          RAM_WORDS       = 64,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] TIMER_RESET_CMP = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        irq,
  output logic        bad_addr
);

  localparam int RIW = $clog2(RAM_WORDS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_STS  = 2'd1;
  localparam logic [1:0] REG_TMR  = 2'd2;
  localparam logic [1:0] REG_TCMP = 2'd3;

  logic           ram_hit;
  logic           per_hit;
  logic [1:0]     sel;
  logic [RIW-1:0] ram_idx;
  logic           wr_out;
  logic           wr_sts;
  logic           wr_tmr;
  logic           wr_tcmp;

  assign ram_hit  = (a[31:8] == 24'd0);
  assign per_hit  = (a[31:4] == 28'h0000010);
  assign sel      = a[3:2];
  assign ram_idx  = a[RIW+1:2];
  assign bad_addr = ~ram_hit & ~per_hit;

  assign wr_out  = we & per_hit & (sel == REG_OUT);
  assign wr_sts  = we & per_hit & (sel == REG_STS);
  assign wr_tmr  = we & per_hit & (sel == REG_TMR);
  assign wr_tcmp = we & per_hit & (sel == REG_TCMP);

  // RAM has no reset so its contents survive reset_n.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we & ram_hit) begin
      ram[ram_idx] <= wd;
    end
  end

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   fcount;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          ovf;

  assign full    = (fcount == FULL_CNT);
  assign empty   = (fcount == '0);
  assign pop     = ~empty & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
  assign push_ok = wr_out & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr] <= wd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
      if (wr_out & full & ~pop) begin
        ovf <= 1'b1;
      end else if (wr_sts & wd[6]) begin
        ovf <= 1'b0;
      end
    end
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? 32'd0 : fifo_mem[rptr];

  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        tmatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcount <= 32'd0;
      tcmp   <= TIMER_RESET_CMP;
      tmatch <= 1'b0;
    end else begin
      tcount <= wr_tmr ? wd : tcount + 32'd1;
      if (wr_tcmp) tcmp <= wd;
      // A match in the same cycle as a clear leaves the flag set.
      if (tcount == tcmp) begin
        tmatch <= 1'b1;
      end else if (wr_sts & wd[2]) begin
        tmatch <= 1'b0;
      end
    end
  end

  assign irq = tmatch;

  logic [31:0] fcount_w;
  logic [31:0] status;

  assign fcount_w = 32'(fcount);
  assign status   = {25'd0, ovf, fcount_w[2:0], tmatch, full, empty};

  always_comb begin
    rd = 32'd0;
    if (ram_hit) begin
      rd = ram[ram_idx];
    end else if (per_hit) begin
      case (sel)
        REG_STS:  rd = status;
        REG_TMR:  rd = tcount;
        REG_TCMP: rd = tcmp;
        default:  rd = 32'd0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{a[1:0], a[7:2], fcount_w[31:3]};

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized and directed bench for dbus_responder against a queue/array reference model.
module tb_dbus_responder;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        irq;
  logic        bad_addr;

  dbus_responder dut (
    .clk(clk), .reset_n(reset_n), .we(we), .a(a), .wd(wd), .rd(rd),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .irq(irq), .bad_addr(bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_ram [64];
  logic [31:0] m_q [$];
  logic [31:0] m_cnt;
  logic [31:0] m_tcmp;
  logic        m_tm;
  logic        m_ovf;

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return {25'd0, m_ovf, 3'(n), m_tm, (n == 4), (n == 0)};
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] ad);
    if (ad < 32'h100) return m_ram[ad[7:2]];
    if (ad >= 32'h100 && ad < 32'h110) begin
      case ((ad - 32'h100) / 4)
        1: return m_status();
        2: return m_cnt;
        3: return m_tcmp;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_cnt = 0;
    m_tcmp = 32'hFFFF_FFFF;
    m_tm = 0;
    m_ovf = 0;
  endtask

  // Applies the effects of one rising edge given the inputs currently driven.
  task automatic m_edge();
    bit per, ram, matched, popped;
    int reg_n, n;
    ram = (a < 32'h100);
    per = (a >= 32'h100 && a < 32'h110);
    reg_n = int'((a - 32'h100) / 4);
    matched = (m_cnt == m_tcmp);
    n = m_q.size();
    popped = (n > 0) && out_ready;
    if (we && ram) m_ram[a[7:2]] = wd;
    if (popped) void'(m_q.pop_front());
    if (we && per && reg_n == 0) begin
      if (n < 4 || popped) m_q.push_back(wd);
      else m_ovf = 1;
    end
    if (we && per && reg_n == 1) begin
      if (wd[6] && !(n == 4 && !popped && 0)) begin
        if (!(we && per && reg_n == 0)) m_ovf = 0;
      end
      if (wd[2]) m_tm = 0;
    end
    if (matched) m_tm = 1;
    if (we && per && reg_n == 3) m_tcmp = wd;
    m_cnt = (we && per && reg_n == 2) ? wd : m_cnt + 1;
  endtask

  task automatic check_outputs();
    chk("rd", rd, m_rd(a));
    chk("bad_addr", {31'd0, bad_addr}, {31'd0, !((a < 32'h100) || (a >= 32'h100 && a < 32'h110))});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
    chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 32'd0);
    chk("irq", {31'd0, irq}, {31'd0, m_tm});
  endtask

  task automatic apply(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    we = w; a = ad; wd = d; out_ready = rdy;
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
  endtask

  task automatic step(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic rdy);
    apply(w, ad, d, rdy);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; we = 0; a = 32'h104; wd = 0; out_ready = 0;
    m_reset();
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_status", rd, 32'h01);
    #6 reset_n = 1'b1;

    for (int i = 0; i < 64; i++) step(1, i * 4, $urandom, 0);

    // RAM
    step(1, 32'h64, 32'd7, 0);
    step(1, 32'h60, 32'h55, 0);
    apply(0, 32'h64, 0, 0); chk("ram_64", rd, 32'd7); tick();
    apply(0, 32'h66, 0, 0); chk("ram_66", rd, 32'd7); tick();
    apply(0, 32'h60, 0, 0); chk("ram_60", rd, 32'h55); chk("ram_bad", {31'd0, bad_addr}, 32'd0); tick();

    // FIFO fill / overflow / drain
    for (int i = 1; i <= 4; i++) step(1, 32'h100, i, 0);
    apply(0, 32'h104, 0, 0); chk("st_full", rd, 32'h22); tick();
    step(1, 32'h100, 32'd5, 0);
    apply(0, 32'h104, 0, 0); chk("st_ovf", rd, 32'h62); chk("head_1", out_data, 32'd1); tick();
    step(1, 32'h104, 32'h40, 0);
    apply(0, 32'h104, 0, 0); chk("st_ovf_clr", rd, 32'h22); tick();
    for (int i = 1; i <= 4; i++) begin
      apply(0, 32'h104, 0, 1); chk("drain", out_data, i); tick();
    end
    apply(0, 32'h104, 0, 1);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);
    chk("drained_data", out_data, 32'd0);
    chk("drained_st", rd, 32'h01);
    tick();
    for (int i = 0; i < 4; i++) step(1, 32'h100, 32'h10 + i, 0);
    step(1, 32'h100, 32'h99, 1);
    apply(0, 32'h104, 0, 0); chk("push_pop_full", rd, 32'h22); tick();
    for (int i = 0; i < 4; i++) step(0, 32'h104, 0, 1);

    // Timer
    step(1, 32'h10C, 32'd10, 0);
    step(1, 32'h108, 32'd5, 0);
    apply(0, 32'h108, 0, 0); chk("tmr_load", rd, 32'd5); tick();
    for (int i = 0; i < 4; i++) step(0, 32'h108, 0, 0);
    apply(0, 32'h108, 0, 0); chk("tmr_at_cmp", rd, 32'd10); chk("irq_before", {31'd0, irq}, 32'd0); tick();
    apply(0, 32'h108, 0, 0); chk("irq_after", {31'd0, irq}, 32'd1); tick();
    step(1, 32'h104, 32'h04, 0);
    apply(0, 32'h104, 0, 0); chk("irq_w1c", {31'd0, irq}, 32'd0); tick();
    step(1, 32'h108, 32'hFFFF_FFFF, 0);
    apply(0, 32'h108, 0, 0); chk("tmr_max", rd, 32'hFFFF_FFFF); tick();
    apply(0, 32'h108, 0, 0); chk("tmr_wrap", rd, 32'd0); tick();

    // Bad address
    apply(0, 32'h200, 0, 0); chk("bad_200_rd", rd, 0); chk("bad_200", {31'd0, bad_addr}, 32'd1); tick();
    apply(0, 32'h110, 0, 0); chk("bad_110_rd", rd, 0); chk("bad_110", {31'd0, bad_addr}, 32'd1); tick();
    step(1, 32'h200, 32'hDEAD_BEEF, 0);
    step(0, 32'h000, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ad, d;
      int r;
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 4) ad = {24'd0, 8'($urandom)};
      else if (r < 8) begin
        ad = 32'h100 + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
        if (ad[3:2] == 2'd3) d = m_cnt + $urandom_range(1, 30);
        if (ad[3:2] == 2'd2 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF - $urandom_range(0, 3);
        if (ad[3:2] == 2'd2 && $urandom_range(0, 1) == 0) d = m_tcmp - $urandom_range(0, 5);
      end else if (r == 8) ad = $urandom;
      else ad = 32'h110 + $urandom_range(0, 32'hEF);
      step(1'($urandom), ad, d, 1'($urandom));
    end

    // Async reset mid-cycle with FIFO entries and irq pending
    step(1, 32'h80, 32'hCAFE_0001, 1);
    step(1, 32'h100, 32'hA1, 0);
    step(1, 32'h100, 32'hA2, 0);
    step(1, 32'h108, 32'd100, 0);
    step(1, 32'h10C, 32'd101, 0);
    step(0, 32'h104, 0, 0);
    apply(0, 32'h104, 0, 0);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_status", rd, 32'h01);
    a = 32'h80;
    #1;
    chk("arst_ram", rd, 32'hCAFE_0001);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) step(0, 32'h108, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
